// File: rtl/spi_config_receiver.sv
// SPI-slave configuration receiver. It oversamples the SPI pins in the clk domain and double-buffers
// each length-checked frame, commits it to cfg on a sample tick and self-clears the command bits one tick later.
module spi_config_receiver #(
    parameter int                    FRAME_BITS      = 256,
    parameter bit                    LSB_FIRST       = 1'b1,
    parameter logic [FRAME_BITS-1:0] SELF_CLEAR_MASK = '0,
    parameter int                    SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic                  sample_tick,
    output logic [FRAME_BITS-1:0] cfg,
    output logic                  cfg_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [7:0]            err_cnt
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   sclk_s, csn_s, mosi_s;
    logic                   sclk_rise, sclk_fall, csn_fall, csn_rise;

    state_t                 state_q, state_d;
    logic                   commit, clear_go;

    logic [FRAME_BITS-1:0]  sr_q, sr_d, shadow_q, shadow_d, cfg_q, cfg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             miso_sr_q, miso_sr_d, err_cnt_q, err_cnt_d, status;
    logic [3:0]             frame_cnt_q, frame_cnt_d;
    logic                   miso_q, miso_d, pending_q, pending_d;
    logic                   cfg_valid_q, cfg_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                   frame_ok, frame_bad;

    // Idle levels of the synchronisers match an idle bus so reset release creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~csn_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~csn_s;
    assign csn_fall  = ~csn_s & csn_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_tick && pending_q) state_d = S_CLEAR;
            S_CLEAR: if (sample_tick)              state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        commit   = (state_q == S_IDLE) && sample_tick && pending_q;
        clear_go = (state_q == S_CLEAR) && sample_tick;
    end

    assign status    = {frame_cnt_q, err_cnt_q[3:0]};
    assign frame_ok  = csn_rise && (bit_cnt_q == CNT_FULL);
    assign frame_bad = csn_rise && (bit_cnt_q != CNT_FULL);

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        miso_d    = miso_q;
        miso_sr_d = miso_sr_q;
        if (csn_fall) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            if (LSB_FIRST) sr_d = {mosi_s, sr_q[FRAME_BITS-1:1]};
            else           sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // Status MSB is presented at csn fall so the master's first rising edge samples it.
        if (csn_fall) begin
            miso_d    = status[7];
            miso_sr_d = {status[6:0], 1'b0};
        end else if (sclk_fall) begin
            miso_d    = miso_sr_q[7];
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end
    end

    always_comb begin
        shadow_d    = frame_ok ? sr_q : shadow_q;
        frame_cnt_d = frame_ok ? frame_cnt_q + 4'd1 : frame_cnt_q;
        // A frame landing in the commit cycle becomes the new pending frame; the old one is not lost.
        pending_d   = frame_ok ? 1'b1 : (commit ? 1'b0 : pending_q);
        overrun_d   = frame_ok && pending_q && !commit;
        frame_err_d = frame_bad;
        err_cnt_d   = (frame_bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        cfg_valid_d = commit;
        if (commit)        cfg_d = shadow_q;
        else if (clear_go) cfg_d = cfg_q & ~SELF_CLEAR_MASK;
        else               cfg_d = cfg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            bit_cnt_q   <= '0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            pending_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_sr_q   <= miso_sr_d;
            miso_q      <= miso_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pending_q   <= pending_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign spi_miso  = miso_q;
    assign cfg       = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign err_cnt   = err_cnt_q;

endmodule
